// File: rtl/addr8u_tmr_sched.sv
// addr8u_tmr_sched: two-requester scheduler for a shared 8-bit unsigned adder.
// Each accepted request runs twice on the adder, with the operands swapped on
// the second run (time redundancy). When the two results disagree the pair of
// runs is repeated, up to MAX_RETRY extra times. The final result is returned
// on a valid/ready response port, with an error flag if the mismatch was never
// resolved. Grants alternate round-robin between the two requesters.
module addr8u_tmr_sched #(
  parameter int MAX_RETRY = 2,  // re-executions after a mismatch, 0..7
  parameter int SAT_ERR   = 1   // 1: err_count saturates at 255, 0: wraps
) (
  input  logic       clk,
  input  logic       rst,
  // requester 0
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  // requester 1
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  // shared external adder
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  input  logic [8:0] add_o,
  // response
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [8:0] rsp_sum,
  output logic       rsp_err,
  output logic [7:0] err_count,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN1 = 2'd1,
    RUN2 = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);
  localparam logic       SATURATE    = (SAT_ERR != 0);

  state_t     state;
  state_t     state_next;
  logic       prio;        // requester currently holding priority
  logic [7:0] op_a;        // operands latched at accept
  logic [7:0] op_b;
  logic       id;          // owner of the transaction in flight
  logic [8:0] r1;          // first-run result
  logic [2:0] retry;       // re-executions used so far
  logic [8:0] sum;
  logic       err;
  logic [7:0] err_cnt;

  logic       grant0;
  logic       grant1;
  logic       accept;
  logic       mismatch;
  logic       retry_left;
  logic       handshake;

  // Arbitration: the priority requester wins when valid, otherwise the other.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (prio == 1'b0) begin
        grant0 = req0_valid;
        grant1 = !req0_valid && req1_valid;
      end else begin
        grant1 = req1_valid;
        grant0 = !req1_valid && req0_valid;
      end
    end
  end

  // Ready is purely combinational from the grant; held low while in reset.
  assign req0_ready = grant0 && !rst;
  assign req1_ready = grant1 && !rst;
  assign accept     = grant0 || grant1;

  assign mismatch   = (add_o != r1);
  assign retry_left = (retry < RETRY_LIMIT);
  assign handshake  = (state == RESP) && rsp_ready;

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = RUN1;
      RUN1: state_next = RUN2;
      RUN2: begin
        if (mismatch && retry_left) state_next = RUN1;
        else                        state_next = RESP;
      end
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Adder operand mux: straight in RUN1, swapped in RUN2, zero otherwise.
  always_comb begin
    add_a = 8'd0;
    add_b = 8'd0;
    case (state)
      RUN1: begin
        add_a = op_a;
        add_b = op_b;
      end
      RUN2: begin
        add_a = op_b;
        add_b = op_a;
      end
      default: begin
        add_a = 8'd0;
        add_b = 8'd0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Transaction context: operands, owner and retry count captured at accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a  <= 8'd0;
      op_b  <= 8'd0;
      id    <= 1'b0;
      retry <= 3'd0;
    end else if (state == IDLE && accept) begin
      op_a  <= grant1 ? req1_a : req0_a;
      op_b  <= grant1 ? req1_b : req0_b;
      id    <= grant1;
      retry <= 3'd0;
    end else if (state == RUN2 && mismatch && retry_left) begin
      retry <= retry + 3'd1;
    end
  end

  // First-run result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r1 <= 9'd0;
    else if (state == RUN1) r1 <= add_o;
  end

  // Response payload is loaded only when leaving RUN2 towards RESP,
  // so it stays stable for the whole RESP phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= 9'd0;
      err <= 1'b0;
    end else if (state == RUN2 && !(mismatch && retry_left)) begin
      sum <= r1;
      err <= mismatch;
    end
  end

  // Mismatch event counter, saturating or wrapping by parameter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (state == RUN2 && mismatch) begin
      if (!(SATURATE && err_cnt == 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

  // Round-robin: after a response is taken, priority goes to the other side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            prio <= 1'b0;
    else if (handshake) prio <= ~id;
  end

  assign rsp_valid = (state == RESP);
  assign rsp_id    = id;
  assign rsp_sum   = sum;
  assign rsp_err   = err;
  assign err_count = err_cnt;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_addr8u_tmr_sched.sv
// Directed testbench for addr8u_tmr_sched: default instance (MAX_RETRY=2,
// SAT_ERR=1) with a configurable faulty adder model, plus a second instance
// (MAX_RETRY=0, SAT_ERR=0) fed by an adder that is always faulty.
module tb_addr8u_tmr_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // main instance signals
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a = 8'd0, req0_b = 8'd0, req1_a = 8'd0, req1_b = 8'd0;
  logic [7:0] add_a, add_b;
  logic [8:0] add_o;
  logic       rsp_valid, rsp_id, rsp_err, busy;
  logic       rsp_ready = 1'b0;
  logic [8:0] rsp_sum;
  logic [7:0] err_count;

  // second instance signals
  logic       x_req0_valid = 1'b0;
  logic       x_req0_ready, x_req1_ready;
  logic [7:0] x_req0_a = 8'd0, x_req0_b = 8'd0;
  logic [7:0] x_add_a, x_add_b;
  logic [8:0] x_add_o;
  logic       x_rsp_valid, x_rsp_id, x_rsp_err, x_busy;
  logic       x_rsp_ready = 1'b0;
  logic [8:0] x_rsp_sum;
  logic [7:0] x_err_count;

  // adder fault controls
  logic       stuck   = 1'b0;  // bit 0 stuck low whenever add_a is odd
  logic       corrupt = 1'b0;  // flip bit 0 when add_a == 8'h20

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Adder model for the main instance.
  always_comb begin
    add_o = {1'b0, add_a} + {1'b0, add_b};
    if (stuck && add_a[0]) add_o[0] = 1'b0;
    if (corrupt && add_a == 8'h20) add_o[0] = ~add_o[0];
  end

  // Always-faulty adder for the second instance.
  always_comb begin
    x_add_o = {1'b0, x_add_a} + {1'b0, x_add_b};
    if (x_add_a[0]) x_add_o[0] = 1'b0;
  end

  addr8u_tmr_sched #(.MAX_RETRY(2), .SAT_ERR(1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .add_a(add_a), .add_b(add_b), .add_o(add_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_err(rsp_err), .err_count(err_count), .busy(busy)
  );

  addr8u_tmr_sched #(.MAX_RETRY(0), .SAT_ERR(0)) u_dut_x (
    .clk(clk), .rst(rst),
    .req0_valid(x_req0_valid), .req0_ready(x_req0_ready), .req0_a(x_req0_a), .req0_b(x_req0_b),
    .req1_valid(1'b0), .req1_ready(x_req1_ready), .req1_a(8'd0), .req1_b(8'd0),
    .add_a(x_add_a), .add_b(x_add_b), .add_o(x_add_o),
    .rsp_valid(x_rsp_valid), .rsp_ready(x_rsp_ready), .rsp_id(x_rsp_id),
    .rsp_sum(x_rsp_sum), .rsp_err(x_rsp_err), .err_count(x_err_count), .busy(x_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // ---- reset values (req0_valid high to confirm ready is held low)
    req0_valid = 1'b1;
    wait_neg(2);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_err", rsp_err, 0);

    // ---- basic transaction: 0xFF + 0x01, response at cycle 3
    rst = 1'b0; req0_a = 8'hFF; req0_b = 8'h01;
    #1;
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_neg(1);
    chk("t1_run1_busy", busy, 1);
    chk("t1_run1_add_a", add_a, 8'hFF);
    chk("t1_run1_add_b", add_b, 8'h01);
    chk("t1_run1_ready0", req0_ready, 0);
    wait_neg(1);
    chk("t1_run2_add_a", add_a, 8'h01);
    chk("t1_run2_add_b", add_b, 8'hFF);
    chk("t1_run2_rsp_valid", rsp_valid, 0);
    wait_neg(1);
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_sum", rsp_sum, 9'h100);
    chk("t1_rsp_err", rsp_err, 0);
    chk("t1_rsp_id", rsp_id, 0);
    chk("t1_resp_add_a", add_a, 0);
    $display("txn id=%0d sum=%0h err=%0d", rsp_id, rsp_sum, rsp_err);
    rsp_ready = 1'b1;
    wait_neg(1);
    chk("t1_done_valid", rsp_valid, 0);
    chk("t1_done_busy", busy, 0);
    rsp_ready = 1'b0;

    // ---- priority now with requester 1; stall response for 10 cycles,
    //      change operands after accept
    req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22;
    req1_valid = 1'b1; req1_a = 8'h40; req1_b = 8'h05;
    #1;
    chk("t2_ready1", req1_ready, 1);
    chk("t2_ready0", req0_ready, 0);
    @(posedge clk); #1 req1_a = 8'hAA; req1_b = 8'hBB;
    wait_neg(3);
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold_valid", rsp_valid, 1);
      chk("t2_hold_sum", rsp_sum, 9'h045);
      chk("t2_hold_id", rsp_id, 1);
      chk("t2_hold_err", rsp_err, 0);
      chk("t2_hold_ready0", req0_ready, 0);
      chk("t2_hold_ready1", req1_ready, 0);
      wait_neg(1);
    end
    $display("txn id=%0d sum=%0h err=%0d", rsp_id, rsp_sum, rsp_err);
    rsp_ready = 1'b1;
    wait_neg(1);
    chk("t2_after_valid", rsp_valid, 0);
    chk("t2_rr_ready0", req0_ready, 1);
    chk("t2_rr_ready1", req1_ready, 0);

    // ---- both valid, rsp_ready high: grants 0,1,0,1 every 4 cycles
    req0_a = 8'd1; req0_b = 8'd2; req1_a = 8'd3; req1_b = 8'd4;
    for (int k = 0; k < 4; k++) begin
      chk("rr_ready0", req0_ready, (k % 2 == 0) ? 1 : 0);
      chk("rr_ready1", req1_ready, (k % 2 == 1) ? 1 : 0);
      wait_neg(3);
      chk("rr_rsp_valid", rsp_valid, 1);
      chk("rr_rsp_id", rsp_id, k % 2);
      chk("rr_rsp_sum", rsp_sum, (k % 2 == 1) ? 9'h007 : 9'h003);
      $display("txn id=%0d sum=%0h err=%0d", rsp_id, rsp_sum, rsp_err);
      wait_neg(1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_end_busy", busy, 0);

    // ---- first RUN2 corrupted: one retry, response at cycle 5
    corrupt = 1'b1;
    req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h20;
    #1;
    chk("t3_ready0", req0_ready, 1);
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_neg(3);
    chk("t3_c3_valid", rsp_valid, 0);
    chk("t3_c3_rerun_add_a", add_a, 8'h10);
    chk("t3_c3_err_count", err_count, 1);
    corrupt = 1'b0;
    wait_neg(2);
    chk("t3_rsp_valid", rsp_valid, 1);
    chk("t3_rsp_sum", rsp_sum, 9'h030);
    chk("t3_rsp_err", rsp_err, 0);
    chk("t3_err_count", err_count, 1);
    $display("txn id=%0d sum=%0h err=%0d", rsp_id, rsp_sum, rsp_err);
    wait_neg(1);
    chk("t3_done_busy", busy, 0);
    chk("t3_done_valid", rsp_valid, 0);

    // ---- persistent fault on req1: 3 mismatches, error response at cycle 7
    stuck = 1'b1;
    req1_valid = 1'b1; req1_a = 8'h03; req1_b = 8'h04;
    #1;
    chk("t4_ready1", req1_ready, 1);
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_neg(6);
    chk("t4_c6_valid", rsp_valid, 0);
    chk("t4_c6_add_b", add_b, 8'h03);
    wait_neg(1);
    chk("t4_rsp_valid", rsp_valid, 1);
    chk("t4_rsp_sum", rsp_sum, 9'h006);
    chk("t4_rsp_err", rsp_err, 1);
    chk("t4_rsp_id", rsp_id, 1);
    chk("t4_err_count", err_count, 4);
    $display("txn id=%0d sum=%0h err=%0d", rsp_id, rsp_sum, rsp_err);
    wait_neg(1);
    chk("t4_done_busy", busy, 0);
    stuck = 1'b0;

    // ---- reset during RUN2 aborts the transaction
    req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h06;
    #1;
    chk("t5_ready0", req0_ready, 1);
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_neg(2);
    chk("t5_run2_add_a", add_a, 8'h06);
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_valid", rsp_valid, 0);
    chk("t5_rst_err_count", err_count, 0);
    chk("t5_rst_sum", rsp_sum, 0);
    chk("t5_rst_err", rsp_err, 0);
    chk("t5_rst_id", rsp_id, 0);
    chk("t5_rst_add_a", add_a, 0);
    chk("t5_rst_add_b", add_b, 0);
    wait_neg(1);
    rst = 1'b0;
    wait_neg(3);
    chk("t5_no_rsp", rsp_valid, 0);
    chk("t5_idle", busy, 0);
    $display("txn aborted by reset");

    // ---- saturation: 85 faulty transactions -> 255, one more stays 255
    stuck = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 8'h03; req0_b = 8'h04;
    wait_neg(8);
    chk("sat_first_err_count", err_count, 3);
    wait_neg(84 * 8);
    chk("sat_err_count_255", err_count, 8'hFF);
    chk("sat_ready0", req0_ready, 1);
    wait_neg(7);
    chk("sat_rsp_valid", rsp_valid, 1);
    chk("sat_rsp_err", rsp_err, 1);
    chk("sat_err_count_hold", err_count, 8'hFF);
    $display("txn id=%0d sum=%0h err=%0d err_count=%0d", rsp_id, rsp_sum, rsp_err, err_count);
    wait_neg(1);
    req0_valid = 1'b0;
    stuck = 1'b0;

    // ---- MAX_RETRY=0, SAT_ERR=0: first mismatch reported, counter wraps
    x_req0_valid = 1'b1; x_req0_a = 8'h03; x_req0_b = 8'h04; x_rsp_ready = 1'b1;
    #1;
    chk("x_ready0", x_req0_ready, 1);
    wait_neg(3);
    chk("x_rsp_valid", x_rsp_valid, 1);
    chk("x_rsp_err", x_rsp_err, 1);
    chk("x_rsp_sum", x_rsp_sum, 9'h006);
    chk("x_rsp_id", x_rsp_id, 0);
    chk("x_err_count", x_err_count, 1);
    $display("txn x id=%0d sum=%0h err=%0d", x_rsp_id, x_rsp_sum, x_rsp_err);
    wait_neg(1 + 255 * 4);
    chk("x_err_count_wrap", x_err_count, 0);
    x_req0_valid = 1'b0;
    wait_neg(4);
    chk("x_idle", x_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
